hex_digit_counter: RTL and testbench
====================================

Name: hex_digit_counter

Overview:
- Multi-digit hexadecimal up/down counter with a run/stop control FSM and a clock prescaler.
- Sits directly upstream of the per-digit hex-to-7-segment decoders. Each 4-bit slice of oDigits drives one decoder input.
- Provides the count value, the run status and a wrap pulse to board-level logic.

Parameters:
- DIGITS, 4, number of hex digits. Counter width is 4*DIGITS bits.
- PRESCALE, 50000000, clk cycles per count step. Gives 1 Hz at 50 MHz. Must be >= 2.
- PS_W, 26, prescaler register width. Must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- iStart  input  1  single-cycle pulse; requests RUN.
- iStop  input  1  single-cycle pulse; requests STOP.
- iUp  input  1  direction: 1 = count up, 0 = count down. Sampled on each step.
- iLoad  input  1  single-cycle pulse; loads iLoadVal into the counter.
- iLoadVal  input  4*DIGITS  preset value. Digit 0 is bits [3:0].
- oDigits  output  4*DIGITS  registered count. Digit k is bits [4k+3:4k] and feeds decoder k.
- oRun  output  1  1 while the FSM is in RUN.
- oWrap  output  1  one-cycle pulse when the count wraps.

Behaviour:
- Reset (rst=1 at a clk edge; overrides every other input):
  - state=STOP, oDigits=0, prescaler=0, oRun=0, oWrap=0.
- FSM states: STOP, RUN. Encoding is binary, 1 bit.
  - STOP -> RUN when iStart=1 and iStop=0.
  - RUN -> STOP when iStop=1.
  - iStart and iStop high together: stop wins, so the next state is STOP.
  - iStart while already in RUN and iStop while already in STOP are ignored.
- oRun is the registered state. It changes on the edge after the request.
- Prescaler:
  - In RUN it increments each cycle.
  - When it equals PRESCALE-1, an internal step occurs: the prescaler returns to 0 on the next edge.
  - In STOP the prescaler holds its value; it is not cleared.
- Step, registered (oDigits changes on the same edge the prescaler returns to 0):
  - Up: oDigits+1, with digit-wise carry (F->0 carries into the next digit).
  - Down: oDigits-1, with digit-wise borrow.
  - Arithmetic is modulo 2^(4*DIGITS).
- Wrap:
  - Up from all-F to 0, or down from 0 to all-F, sets oWrap=1 for exactly one cycle.
  - oWrap is coincident with the wrapped value appearing on oDigits. Otherwise oWrap=0.
- Load:
  - iLoad=1 sets oDigits=iLoadVal and the prescaler to 0 on the next edge, in either state.
  - The state is not changed. No oWrap is generated.
  - Load has priority over a step in the same cycle; the step is discarded.
- A stop request in the same cycle as a step: the step is still applied and the FSM enters STOP.
- Changing iUp between steps takes effect at the next step only. No glitching of oDigits.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package hex_disp_pkg:
  - state enum (ST_STOP, ST_RUN).
  - DIGIT_W=4.
  - constants DIGIT_MAX=4'hF and DIGIT_MIN=4'h0.
- Natural sub-module hex_digit_cell: one 4-bit up/down digit.
  - Inputs: step-enable, carry/borrow in, direction, load value.
  - Outputs: the digit, plus carry/borrow out when the digit is at F (up) or at 0 (down) and enabled.
  - Instantiated DIGITS times by a generate loop.
  - Top-level oWrap = carry/borrow out of the last cell.

Test Plan (PRESCALE=4, DIGITS=4):
1. Reset, then iStart pulse -> oRun=1 next cycle. oDigits=0001 four cycles after RUN is entered, then 0002 four cycles later.
2. iLoad with iLoadVal=16'h00FF, iUp=1, RUN -> one step later oDigits=0100; carry propagates across two digits in one cycle.
3. Load 16'hFFFF, iUp=1, RUN -> next step oDigits=0000 with oWrap=1 for exactly one cycle. With iUp=0 from 0000 -> FFFF and oWrap=1.
4. iStart and iStop pulsed in the same cycle while in STOP -> state stays STOP, oRun=0. In RUN, iStop on the step cycle -> step applied, then STOP, then the count holds indefinitely.
5. iLoad=1 on the step cycle with iLoadVal=16'h1234 -> oDigits=1234, not 1235, and the prescaler restarts from 0.
6. rst asserted mid-RUN with oDigits=ABCD -> next edge oDigits=0000, oRun=0, oWrap=0. Inputs during rst are ignored.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display counter slice.
package hex_disp_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'hF;
    localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'h0;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/hex_digit_cell.sv
// One 4-bit hex digit with load, up/down step and ripple carry/borrow.
module hex_digit_cell
    import hex_disp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               en,
    input  logic               cin,
    input  logic               up,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout_c
);

    // Carry (up) or borrow (down) leaves this digit only when it rolls over.
    always_comb begin
        cout_c = 1'b0;
        if (en && cin) begin
            cout_c = up ? (digit == DIGIT_MAX) : (digit == DIGIT_MIN);
        end
    end

    // Digit register: load beats a step; a step only moves the digit when the lower digits roll.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= DIGIT_MIN;
        end else if (load) begin
            digit <= load_val;
        end else if (en && cin) begin
            digit <= up ? digit + DIGIT_W'(1) : digit - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/hex_digit_counter.sv
// Multi-digit hex up/down counter with run/stop control and a step prescaler.
module hex_digit_counter
    import hex_disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PS_W     = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iStart,
    input  logic                  iStop,
    input  logic                  iUp,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iLoadVal,
    output logic [4*DIGITS-1:0]   oDigits,
    output logic                  oRun,
    output logic                  oWrap
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t            state_q;
    state_t            state_d;
    logic [PS_W-1:0]   ps_q;
    logic              step_c;
    logic              step_en_c;
    logic [DIGITS:0]   carry_c;

    // Next-state logic: a stop request always wins over a start request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (iStart && !iStop) state_d = ST_RUN;
            ST_RUN:  if (iStop)            state_d = ST_STOP;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    assign oRun = (state_q == ST_RUN);

    // A step fires on the last prescaler count while running; a load discards it.
    assign step_c    = (state_q == ST_RUN) && (ps_q == PS_LAST);
    assign step_en_c = step_c && !iLoad;

    // Prescaler: counts only in RUN, holds in STOP, restarts on load or step.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else if (iLoad || step_c) begin
            ps_q <= '0;
        end else if (state_q == ST_RUN) begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // Digit chain: digit 0 always sees an incoming carry so it moves on every step.
    assign carry_c[0] = 1'b1;

    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
        hex_digit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .load     (iLoad),
            .load_val (iLoadVal[4*k +: 4]),
            .en       (step_en_c),
            .cin      (carry_c[k]),
            .up       (iUp),
            .digit    (oDigits[4*k +: 4]),
            .cout_c   (carry_c[k+1])
        );
    end

    // Wrap pulse: carry/borrow out of the top digit, registered alongside the wrapped value.
    always_ff @(posedge clk) begin
        if (rst) begin
            oWrap <= 1'b0;
        end else begin
            oWrap <= step_en_c && carry_c[DIGITS];
        end
    end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Randomized and directed bench for hex_digit_counter against an arithmetic reference model.
module tb_hex_digit_counter;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PS_W     = 3;
    localparam int          MODULUS  = 65536;

    logic        clk;
    logic        rst;
    logic        iStart;
    logic        iStop;
    logic        iUp;
    logic        iLoad;
    logic [15:0] iLoadVal;
    logic [15:0] oDigits;
    logic        oRun;
    logic        oWrap;

    int n_cmp;
    int n_bad;

    int m_cnt;
    int m_ps;
    bit m_run;
    bit m_wrap;
    bit cur_up;

    hex_digit_counter #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iStop    (iStop),
        .iUp      (iUp),
        .iLoad    (iLoad),
        .iLoadVal (iLoadVal),
        .oDigits  (oDigits),
        .oRun     (oRun),
        .oWrap    (oWrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference model, compare all outputs.
    task automatic tick(input bit r, input bit s, input bit p, input bit u,
                        input bit l, input logic [15:0] v);
        bit step;
        @(negedge clk);
        rst = r; iStart = s; iStop = p; iUp = u; iLoad = l; iLoadVal = v;
        if (r) begin
            m_cnt = 0; m_ps = 0; m_run = 0; m_wrap = 0;
        end else begin
            step   = m_run && (m_ps == PRESCALE - 1);
            m_wrap = 0;
            if (l) begin
                m_cnt = int'(v);
                m_ps  = 0;
            end else if (step) begin
                m_wrap = u ? (m_cnt == MODULUS - 1) : (m_cnt == 0);
                m_cnt  = (m_cnt + (u ? 1 : MODULUS - 1)) % MODULUS;
                m_ps   = 0;
            end else if (m_run) begin
                m_ps = m_ps + 1;
            end
            if (p)      m_run = 0;
            else if (s) m_run = 1;
        end
        @(posedge clk);
        #1;
        check("digits", 32'(oDigits), 32'(m_cnt));
        check("run",    32'(oRun),    32'(m_run));
        check("wrap",   32'(oWrap),   32'(m_wrap));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, cur_up, 0, 16'h0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cur_up = 1;
        rst = 1; iStart = 0; iStop = 0; iUp = 1; iLoad = 0; iLoadVal = '0;

        // Reset state
        tick(1, 0, 0, 1, 0, 16'h0);
        tick(1, 0, 0, 1, 0, 16'h0);
        check("rst_digits", 32'(oDigits), 32'h0);
        check("rst_run",    32'(oRun),    32'h0);

        // Start, first steps four cycles apart
        tick(0, 1, 0, 1, 0, 16'h0);
        check("start_run", 32'(oRun), 32'h1);
        idle(4);
        check("step1", 32'(oDigits), 32'h0001);
        idle(4);
        check("step2", 32'(oDigits), 32'h0002);

        // Carry across two digits
        tick(0, 0, 0, 1, 1, 16'h00FF);
        idle(4);
        check("carry2", 32'(oDigits), 32'h0100);

        // Up wrap, then down wrap
        tick(0, 0, 0, 1, 1, 16'hFFFF);
        idle(4);
        check("wrap_up_val", 32'(oDigits), 32'h0000);
        check("wrap_up",     32'(oWrap),   32'h1);
        idle(1);
        check("wrap_pulse_end", 32'(oWrap), 32'h0);
        cur_up = 0;
        idle(3);
        check("wrap_dn_val", 32'(oDigits), 32'hFFFF);
        check("wrap_dn",     32'(oWrap),   32'h1);
        cur_up = 1;

        // Start+stop together in STOP stays stopped
        tick(0, 0, 1, 1, 0, 16'h0);
        tick(0, 1, 1, 1, 0, 16'h0);
        check("startstop", 32'(oRun), 32'h0);

        // Stop on the step cycle: step applied, then count holds
        tick(0, 1, 0, 1, 0, 16'h0);
        tick(0, 0, 0, 1, 1, 16'h0500);
        idle(3);
        tick(0, 0, 1, 1, 0, 16'h0);
        check("stop_step", 32'(oDigits), 32'h0501);
        idle(12);
        check("hold", 32'(oDigits), 32'h0501);

        // Load on the step cycle beats the step, prescaler restarts
        tick(0, 1, 0, 1, 0, 16'h0);
        tick(0, 0, 0, 1, 1, 16'h0042);
        idle(3);
        tick(0, 0, 0, 1, 1, 16'h1234);
        check("load_prio", 32'(oDigits), 32'h1234);
        idle(3);
        check("load_restart", 32'(oDigits), 32'h1234);
        idle(1);
        check("after_load", 32'(oDigits), 32'h1235);

        // Reset mid-run ignores other inputs
        tick(0, 0, 0, 1, 1, 16'hABCD);
        idle(2);
        tick(1, 1, 0, 1, 1, 16'h5555);
        check("midrst_digits", 32'(oDigits), 32'h0);
        check("midrst_run",    32'(oRun),    32'h0);
        check("midrst_wrap",   32'(oWrap),   32'h0);

        // Random phase; loads biased toward wrap boundaries
        for (int i = 0; i < 3000; i++) begin
            bit r, s, p, l;
            logic [15:0] v;
            if ($urandom_range(9) == 0) cur_up = ~cur_up;
            r = ($urandom_range(199) == 0);
            s = ($urandom_range(19) == 0);
            p = ($urandom_range(39) == 0);
            l = ($urandom_range(29) == 0);
            case ($urandom_range(3))
                0:       v = 16'hFFFF;
                1:       v = 16'h0000;
                default: v = 16'($urandom);
            endcase
            tick(r, s, p, cur_up, l, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
